// File: rtl/tmds_multi_encoder.sv
// Multi-lane TMDS encoder: control, video (DVI 8b/10b), TERC4 and guard-band symbols.
// Two enabled pipeline stages; each lane keeps its own running disparity.
module tmds_multi_encoder #(
    parameter int CHANNELS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [8*CHANNELS-1:0]  data,
    input  logic [2*CHANNELS-1:0]  ctrl,
    input  logic [4*CHANNELS-1:0]  terc,
    output logic [10*CHANNELS-1:0] out,
    output logic                   out_valid
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_TERC4  = 3'd2;
    localparam logic [2:0] MODE_VGUARD = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] GUARD_HI = 10'b1011001100;
    localparam logic [9:0] GUARD_LO = 10'b0100110011;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, d[i]};
        return c;
    endfunction

    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = ones8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_00;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] t);
        case (t)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    // Returns {symbol, next disparity}; the sum stays within -16..+14 so 5 bits never wrap.
    function automatic logic [14:0] video_step(input logic [8:0] qm, input logic [3:0] n1,
                                               input logic signed [4:0] cnt);
        logic signed [5:0] n1s, n0s, c, d;
        logic [9:0] w;
        n1s = {2'b00, n1};
        n0s = 6'sd8 - n1s;
        c   = {cnt[4], cnt};
        if ((cnt == 5'sd0) || (n1s == n0s)) begin
            w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            d = qm[8] ? (n1s - n0s) : (n0s - n1s);
        end else if (((cnt > 5'sd0) && (n1s > n0s)) || ((cnt < 5'sd0) && (n0s > n1s))) begin
            w = {1'b1, qm[8], ~qm[7:0]};
            d = (qm[8] ? 6'sd2 : 6'sd0) + (n0s - n1s);
        end else begin
            w = {1'b0, qm[8], qm[7:0]};
            d = (qm[8] ? 6'sd0 : -6'sd2) + (n1s - n0s);
        end
        c = c + d;
        return {w, c[4:0]};
    endfunction

    // Stage 0 -> 1: transition-minimised q_m and its ones count
    logic [8:0] qm_p0 [CHANNELS];
    logic [3:0] n1_p0 [CHANNELS];

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            qm_p0[n] = qm_encode(data[8*n +: 8]);
            n1_p0[n] = ones8(qm_p0[n][7:0]);
        end
    end

    logic [2:0] mode_p1;
    logic       vld_p1;
    logic [1:0] ctrl_p1 [CHANNELS];
    logic [3:0] terc_p1 [CHANNELS];
    logic [8:0] qm_p1   [CHANNELS];
    logic [3:0] n1_p1   [CHANNELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_p1 <= MODE_CTRL;
            vld_p1  <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) ctrl_p1[n] <= 2'b00;
        end else if (en) begin
            mode_p1 <= mode;
            vld_p1  <= 1'b1;
            for (int n = 0; n < CHANNELS; n++) ctrl_p1[n] <= ctrl[2*n +: 2];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int n = 0; n < CHANNELS; n++) begin
                terc_p1[n] <= terc[4*n +: 4];
                qm_p1[n]   <= qm_p0[n];
                n1_p1[n]   <= n1_p0[n];
            end
        end
    end

    // Stage 1 -> 2: symbol selection and disparity update
    logic [9:0]        sym_p2  [CHANNELS];
    logic signed [4:0] cnt_p2  [CHANNELS];
    logic              vld_p2;
    logic [9:0]        sym_nxt [CHANNELS];
    logic signed [4:0] cnt_nxt [CHANNELS];

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            sym_nxt[n] = ctrl_code(ctrl_p1[n]);
            cnt_nxt[n] = 5'sd0;
            case (mode_p1)
                MODE_VIDEO:  {sym_nxt[n], cnt_nxt[n]} = video_step(qm_p1[n], n1_p1[n], cnt_p2[n]);
                MODE_TERC4:  sym_nxt[n] = terc4_code(terc_p1[n]);
                MODE_VGUARD: sym_nxt[n] = (n == 1) ? GUARD_LO : GUARD_HI;
                MODE_DGUARD: sym_nxt[n] = (n == 0) ? terc4_code(terc_p1[n]) : GUARD_LO;
                default:     sym_nxt[n] = ctrl_code(ctrl_p1[n]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                sym_p2[n] <= CTRL_00;
                cnt_p2[n] <= 5'sd0;
            end
        end else if (en) begin
            vld_p2 <= vld_p1;
            for (int n = 0; n < CHANNELS; n++) begin
                sym_p2[n] <= sym_nxt[n];
                cnt_p2[n] <= cnt_nxt[n];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign out[10*g +: 10] = sym_p2[g];
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Directed-vector bench for tmds_multi_encoder with four lanes.
module tb_tmds_multi_encoder;

    localparam int CH   = 4;
    localparam int NV   = 35;
    localparam int NRND = 48;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] GHI = 10'b1011001100;
    localparam logic [9:0] GLO = 10'b0100110011;
    localparam logic [9:0] TLUT [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef struct {
        logic [2:0]       mode;
        logic [8*CH-1:0]  data;
        logic [2*CH-1:0]  ctrl;
        logic [4*CH-1:0]  terc;
        logic [10*CH-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic [8*CH-1:0]  data;
    logic [2*CH-1:0]  ctrl;
    logic [4*CH-1:0]  terc;
    logic [10*CH-1:0] out;
    logic             out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t             tbl [NV];
    int               nv;
    int               ref_cnt [CH];
    logic [7:0]       rd  [NRND][CH];
    logic [10*CH-1:0] cap [NRND];

    tmds_multi_encoder #(.CHANNELS(CH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .data(data),
        .ctrl(ctrl), .terc(terc), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [8*CH-1:0] d,
                         input logic [2*CH-1:0] c, input logic [4*CH-1:0] t);
        mode = m;
        data = d;
        ctrl = c;
        terc = t;
    endtask

    task automatic check(input string name, input logic [10*CH-1:0] act, input logic [10*CH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] m, input logic [7:0] d, input logic [2*CH-1:0] c,
                       input logic [4*CH-1:0] t, input logic [10*CH-1:0] e);
        tbl[nv].mode = m;
        tbl[nv].data = {CH{d}};
        tbl[nv].ctrl = c;
        tbl[nv].terc = t;
        tbl[nv].exp  = e;
        nv++;
    endtask

    // DVI 1.0 reference encoder using integer disparity.
    task automatic ref_video(input int lane, input logic [7:0] d, output logic [9:0] w);
        logic [8:0] q;
        int         n1, n0;
        bit         use_xnor;
        use_xnor = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !use_xnor;
        n1 = $countones(q[7:0]);
        n0 = 8 - n1;
        if (ref_cnt[lane] == 0 || n1 == n0) begin
            w = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            ref_cnt[lane] += q[8] ? (n1 - n0) : (n0 - n1);
        end else if ((ref_cnt[lane] > 0 && n1 > n0) || (ref_cnt[lane] < 0 && n0 > n1)) begin
            w = {1'b1, q[8], ~q[7:0]};
            ref_cnt[lane] += (q[8] ? 2 : 0) + (n0 - n1);
        end else begin
            w = {1'b0, q[8], q[7:0]};
            ref_cnt[lane] += (q[8] ? 0 : -2) + (n1 - n0);
        end
    endtask

    initial begin
        logic [4*CH-1:0]  t;
        logic [10*CH-1:0] e;
        logic [10*CH-1:0] held;
        logic [8*CH-1:0]  dv;
        logic [9:0]       w;
        int               rsum [CH];
        int               rmin [CH];
        int               rmax [CH];
        int               nb;

        nv = 0;
        add(3'd0, 8'h00, 8'b00_00_00_00, '0, {CH{C00}});
        add(3'd0, 8'h00, 8'b00_11_10_01, '0, {C00, C11, C10, C01});
        add(3'd3, 8'h00, '0, '0, {GHI, GHI, GLO, GHI});
        add(3'd4, 8'h00, '0, 16'h000C, {GLO, GLO, GLO, TLUT[12]});
        add(3'd5, 8'h00, 8'b11_11_11_11, '0, {CH{C11}});
        add(3'd7, 8'h00, 8'b10_10_10_10, '0, {CH{C10}});
        for (int k = 0; k < 16; k++) begin
            for (int n = 0; n < CH; n++) begin
                t[4*n +: 4]  = 4'((k + n) % 16);
                e[10*n +: 10] = TLUT[(k + n) % 16];
            end
            add(3'd2, 8'h00, '0, t, e);
        end
        add(3'd1, 8'h00, '0, '0, {CH{10'h100}});
        add(3'd1, 8'h55, '0, '0, {CH{10'h133}});
        add(3'd1, 8'h00, '0, '0, {CH{10'h3FF}});
        add(3'd1, 8'hAA, '0, '0, {CH{10'h233}});
        add(3'd1, 8'h00, '0, '0, {CH{10'h100}});
        add(3'd1, 8'h00, '0, '0, {CH{10'h3FF}});
        add(3'd1, 8'hFF, '0, '0, {CH{10'h200}});
        add(3'd1, 8'hFF, '0, '0, {CH{10'h0FF}});
        add(3'd1, 8'h00, '0, '0, {CH{10'h100}});
        add(3'd0, 8'h00, '0, '0, {CH{C00}});
        add(3'd1, 8'h00, '0, '0, {CH{10'h100}});
        add(3'd2, 8'h00, '0, '0, {CH{TLUT[0]}});
        add(3'd1, 8'h00, '0, '0, {CH{10'h100}});

        for (int k = 0; k < NRND; k++)
            for (int n = 0; n < CH; n++) rd[k][n] = 8'($urandom);

        rst_n = 1'b0;
        en    = 1'b1;
        drive(3'd0, '0, '0, '0);
        repeat (3) tick;
        check("reset_out", out, {CH{C00}});
        check1("reset_valid", out_valid, 1'b0);

        rst_n = 1'b1;
        drive(3'd1, '0, '0, '0);
        tick;
        check1("valid_first_edge", out_valid, 1'b0);
        tick;
        check1("valid_second_edge", out_valid, 1'b1);
        check("video00_first", out, {CH{10'h100}});
        tick;
        check("video00_second", out, {CH{10'h3FF}});

        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(tbl[i].mode, tbl[i].data, tbl[i].ctrl, tbl[i].terc);
            else        drive(3'd0, '0, '0, '0);
            tick;
            if (i >= 1) check($sformatf("vec%0d", i - 1), out, tbl[i-1].exp);
        end

        // Random video stream against the reference encoder
        drive(3'd0, '0, '0, '0);
        tick;
        tick;
        for (int n = 0; n < CH; n++) begin
            ref_cnt[n] = 0;
            rsum[n] = 0;
            rmin[n] = 0;
            rmax[n] = 0;
        end
        for (int k = 0; k <= NRND; k++) begin
            if (k < NRND) begin
                for (int n = 0; n < CH; n++) dv[8*n +: 8] = rd[k][n];
                drive(3'd1, dv, '0, '0);
            end else begin
                drive(3'd0, '0, '0, '0);
            end
            tick;
            if (k >= 1) begin
                cap[k-1] = out;
                for (int n = 0; n < CH; n++) begin
                    ref_video(n, rd[k-1][n], w);
                    e[10*n +: 10] = w;
                    rsum[n] += 2 * $countones(out[10*n +: 10]) - 10;
                    if (rsum[n] < rmin[n]) rmin[n] = rsum[n];
                    if (rsum[n] > rmax[n]) rmax[n] = rsum[n];
                end
                check($sformatf("rnd%0d", k - 1), out, e);
            end
        end
        for (int n = 0; n < CH; n++)
            check1($sformatf("disparity_range_lane%0d", n), (rmin[n] >= -16) && (rmax[n] <= 14), 1'b1);

        // Same stream with random stalls and garbage inputs while stalled
        drive(3'd0, '0, '0, '0);
        tick;
        tick;
        held = out;
        for (int k = 0; k <= NRND; k++) begin
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) begin
                en = 1'b0;
                drive(3'($urandom_range(0, 7)), {CH{8'($urandom)}}, 8'($urandom), 16'($urandom));
                tick;
                check($sformatf("stall_hold%0d", k), out, held);
            end
            en = 1'b1;
            if (k < NRND) begin
                for (int n = 0; n < CH; n++) dv[8*n +: 8] = rd[k][n];
                drive(3'd1, dv, '0, '0);
            end else begin
                drive(3'd0, '0, '0, '0);
            end
            tick;
            if (k >= 1) check($sformatf("stall_seq%0d", k - 1), out, cap[k-1]);
            held = out;
        end

        // Asynchronous reset between clock edges in the middle of video
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < CH; n++) dv[8*n +: 8] = rd[k][n];
            drive(3'd1, dv, '0, '0);
            tick;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", out, {CH{C00}});
        check1("async_reset_valid", out_valid, 1'b0);
        tick;
        rst_n = 1'b1;
        drive(3'd3, '0, '0, '0);
        tick;
        check1("post_reset_valid_first", out_valid, 1'b0);
        tick;
        check1("post_reset_valid_second", out_valid, 1'b1);
        check("post_reset_vguard", out, {GHI, GHI, GLO, GHI});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_multi_encoder.md
# tmds_multi_encoder

Parametrised multi-lane TMDS encoder that replaces the single-lane, video/control-only encoder in the HDMI/DVI transmit path. It encodes CHANNELS lanes in parallel and supports five per-cycle modes: control, video data, TERC4 data-island, video guard band and data-island guard band. Each lane has its own running-disparity state, and all lanes share a 2-stage pipeline with clock enable. The block sits between the video timing/packet mux and the 10:1 serialisers.

## Interface
- CHANNELS, 3: number of TMDS lanes; lane 0 = blue/sync, lane 1 = green, lane 2 = red. Any value ≥1 is legal; lanes ≥3 use lane-2 guard codes.
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; when low, all state and outputs hold.
- mode  in  3  0=CTRL, 1=VIDEO, 2=TERC4, 3=VGUARD, 4=DGUARD; 5–7 behave as CTRL.
- data  in  8*CHANNELS  video byte per lane; lane n = data[8n+7:8n].
- ctrl  in  2*CHANNELS  control bits per lane (lane 0 = {vsync,hsync}).
- terc  in  4*CHANNELS  TERC4 nibble per lane.
- out  out  10*CHANNELS  encoded symbol per lane; out[10n+9:10n], bit 0 transmitted first.
- out_valid  out  1  high once the pipeline holds a real symbol since reset.

## Operation
- Stage 1 (registered on en): latch mode, ctrl and terc. Compute the 9-bit q_m per lane from data: XNOR chain (q_m[8]=0) when ones(data)>4, or when ones==4 and data[0]==0; otherwise XOR chain (q_m[8]=1). Latch q_m and its 4-bit ones count N1 (N0 = 8−N1).
- Stage 2 (registered on en): produce out and update the disparity state.
- Per-lane disparity cnt: 5-bit two's complement, equal to running (ones−zeros) of emitted video words. It is always even and stays within −16..+14, so no wrap is possible.
- VIDEO decision, per DVI 1.0:
  - If cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? (N1−N0) : (N0−N1).
  - Else if (cnt>0 && N1>N0) or (cnt<0 && N0>N1): out = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0−N1).
  - Else: out = {0, q_m[8], q_m[7:0]}; cnt += −2*(~q_m[8]) + (N1−N0).
- CTRL: ctrl 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- TERC4 (out[9:0] for nibble 0..F): 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- VGUARD: lanes 0 and 2 emit 1011001100; lane 1 emits 0100110011; lanes ≥3 emit the lane-2 code.
- DGUARD: lane 0 emits the TERC4 code of terc[3:0] of lane 0; lanes ≥1 emit 0100110011.
- Every non-VIDEO stage-2 cycle clears that lane's cnt to 0. Lanes are fully independent.

## Timing
- Reset (asynchronous assert; release synchronous to clk): out = the CTRL-00 code 1101010100 on every lane, cnt = 0, stage-1 mode = CTRL, out_valid = 0.
- Latency is 2 enabled cycles from input sample to out.
- out_valid rises on the second enabled edge after reset release and then stays high until reset.
- en low: inputs are ignored, and out, cnt, stage-1 registers and out_valid hold. Stalls of any length are transparent.
- A mode change takes effect on the symbol itself, with no bubble. The first VIDEO symbol after any non-VIDEO symbol uses cnt=0.
- Reset mid-stream: outputs return immediately to the reset values. In-flight pipeline contents are discarded.

## Test plan
- Reset then mode=VIDEO, data=0x00 on all lanes for 2 cycles: out words are 0x100, then 0x3FF (cnt −8 then +2); out_valid goes high 2 cycles after the first sample.
- Random VIDEO data, 10k cycles, CHANNELS=3: each lane matches the DVI reference model bit-exactly. The running (ones−zeros) of each lane stays within −16..+14.
- mode=CTRL with ctrl 00/01/10/11, then VGUARD, then DGUARD with lane-0 terc=0xC: out shows the listed codes 2 cycles later. Lane 0 shows 1010001110 in DGUARD.
- TERC4 sweep of nibbles 0..F on all lanes: all 16 codes are exact. After a VIDEO burst, cnt is observed back at 0 when the next VIDEO word is encoded.
- en toggled pseudo-randomly during a VIDEO stream: the output sequence with bubbles removed equals the en-always-high sequence.
- rst_n asserted asynchronously mid-VIDEO (between edges), CHANNELS=4: out immediately becomes 1101010100 on all lanes and out_valid=0. After release, lane 3 VGUARD emits 1011001100.
